alu_pipe: RTL and testbench



---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_mul_iter.sv | 44 ++++
 rtl/alu_pipe.sv | 96 +++++++++
 tb/tb_alu_pipe.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM encoding and overflow helper shared by the pipelined ALU
package alu_pkg;
   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_MUL  = 6'b000010;
   localparam logic [5:0] OP_AND  = 6'b000100;
   localparam logic [5:0] OP_OR   = 6'b000101;
   localparam logic [5:0] OP_XOR  = 6'b000110;
   localparam logic [5:0] OP_NOR  = 6'b000111;
   localparam logic [5:0] OP_SLL  = 6'b001000;
   localparam logic [5:0] OP_SRL  = 6'b001001;
   localparam logic [5:0] OP_SRA  = 6'b001010;
   localparam logic [5:0] OP_SLT  = 6'b001011;
   localparam logic [5:0] OP_SLTU = 6'b001100;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   // sa/sb/sr are the sign bits of a, b and the result
   function automatic logic add_sub_ovf(input logic sub, input logic sa, input logic sb, input logic sr);
      return (sub ? sa != sb : sa == sb) && (sr != sa);
   endfunction
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per cycle
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] prod
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         prod   <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else begin
         done <= busy && cnt == LAST;
         if (start) begin
            busy   <= 1'b1;
            prod   <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
         end else if (busy) begin
            prod   <= mplier[0] ? prod + mcand : prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            busy   <= cnt != LAST;
         end
      end
   end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with registered result, single-cycle ops and iterative MUL
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [5:0]       alufn,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] otp,
   output logic             zero,
   output logic             overflow,
   output logic             illegal
);
   logic [1:0]         state;
   logic               accept, mul_start, mul_busy, mul_done, ld, ovf, ill, nxt_ovf, nxt_ill;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   sum, diff, res, nxt_otp;
   logic [SHW-1:0]     sh;
   assign in_ready  = state == S_IDLE && !mul_busy && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && alufn == OP_MUL;
   assign sum       = a + b;
   assign diff      = a - b;
   assign sh        = b[SHW-1:0];
   always_comb begin
      res = '0;
      ovf = 1'b0;
      ill = 1'b0;
      case (alufn)
         OP_ADD: begin
            res = sum;
            ovf = add_sub_ovf(1'b0, a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
         end
         OP_SUB: begin
            res = diff;
            ovf = add_sub_ovf(1'b1, a[WIDTH-1], b[WIDTH-1], diff[WIDTH-1]);
         end
         OP_MUL:  res = '0;
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         OP_NOR:  res = ~(a | b);
         OP_SLL:  res = a << sh;
         OP_SRL:  res = a >> sh;
         OP_SRA:  res = WIDTH'($signed(a) >>> sh);
         OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: res = {{(WIDTH-1){1'b0}}, a < b};
         default: ill = 1'b1;
      endcase
   end
   // result registers load either from a single-cycle accept or from the finished product
   assign ld      = (accept && !mul_start) || state == S_DONE;
   assign nxt_otp = state == S_DONE ? prod[WIDTH-1:0] : res;
   assign nxt_ovf = state == S_DONE ? |prod[2*WIDTH-1:WIDTH] : ovf;
   assign nxt_ill = state != S_DONE && ill;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         otp       <= '0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         state <= state == S_IDLE ? (mul_start ? S_MUL : S_IDLE) :
                  state == S_MUL  ? (mul_done ? S_DONE : S_MUL) : S_IDLE;
         if (ld) begin
            out_valid <= 1'b1;
            otp       <= nxt_otp;
            zero      <= nxt_otp == '0;
            overflow  <= nxt_ovf;
            illegal   <= nxt_ill;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk   (clk),
      .rst   (rst),
      .start (mul_start),
      .a     (a),
      .b     (b),
      .busy  (mul_busy),
      .done  (mul_done),
      .prod  (prod)
   );
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors for alu_pipe at WIDTH=32 and WIDTH=8
module tb_alu_pipe;
   import alu_pkg::*;
   logic        clk, rst, in_valid, in_ready, out_valid, out_ready, zero, overflow, illegal;
   logic [31:0] a, b, otp;
   logic [5:0]  alufn;
   logic        in_valid8, in_ready8, out_valid8, zero8, overflow8, illegal8;
   logic [7:0]  a8, b8, otp8;
   logic [5:0]  alufn8;
   int checks = 0, failures = 0, cnt;
   logic stable;

   alu_pipe #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .alufn(alufn),
      .out_valid(out_valid), .out_ready(out_ready), .otp(otp), .zero(zero), .overflow(overflow), .illegal(illegal)
   );
   alu_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8), .alufn(alufn8),
      .out_valid(out_valid8), .out_ready(1'b1), .otp(otp8), .zero(zero8), .overflow(overflow8), .illegal(illegal8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
      in_valid = 1'b1;
      alufn    = op;
      a        = x;
      b        = y;
   endtask

   // issue a MUL, scramble the inputs while it runs, return cycles from accept edge to out_valid
   task automatic mul_run(input logic [31:0] x, input logic [31:0] y, output int lat);
      drive(OP_MUL, x, y);
      @(negedge clk);
      in_valid = 1'b0;
      a = 32'hdead_beef;
      b = 32'h1234_5678;
      alufn = OP_ADD;
      chk("mul_in_ready", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; alufn = '0;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; alufn8 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_valid", out_valid, 0);
      chk("rst_otp", otp, 0);
      chk("rst_zero", zero, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_ill", illegal, 0);
      chk("rst_ready", in_ready, 1);

      drive(OP_ADD, 32'h7FFF_FFFF, 32'h1);
      @(negedge clk);
      chk("add_valid", out_valid, 1);
      chk("add_otp", otp, 32'h8000_0000);
      chk("add_ovf", overflow, 1);
      drive(OP_SUB, 32'h8000_0000, 32'h1);
      @(negedge clk);
      chk("sub_otp", otp, 32'h7FFF_FFFF);
      chk("sub_ovf", overflow, 1);
      drive(OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F);
      @(negedge clk);
      chk("xor_otp", otp, 32'hF0F0_0F0F);
      chk("xor_ovf", overflow, 0);
      drive(OP_SLT, 32'hFFFF_FFFF, 32'h1);
      @(negedge clk);
      chk("slt_otp", otp, 1);
      drive(OP_SLTU, 32'hFFFF_FFFF, 32'h1);
      @(negedge clk);
      chk("sltu_otp", otp, 0);
      chk("sltu_zero", zero, 1);
      drive(OP_SRA, 32'h8000_0000, 32'h21);
      @(negedge clk);
      chk("sra_otp", otp, 32'hC000_0000);
      drive(OP_SRL, 32'h8000_0000, 32'h21);
      @(negedge clk);
      chk("srl_otp", otp, 32'h4000_0000);
      drive(OP_SLL, 32'h1234_5678, 32'h0);
      @(negedge clk);
      chk("sll0_otp", otp, 32'h1234_5678);
      drive(OP_NOR, 32'h0, 32'h0);
      @(negedge clk);
      chk("nor_otp", otp, 32'hFFFF_FFFF);
      drive(6'b111111, 32'h5, 32'h3);
      @(negedge clk);
      chk("ill_otp", otp, 0);
      chk("ill_flag", illegal, 1);
      chk("ill_zero", zero, 1);
      chk("ill_ovf", overflow, 0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("drain_valid", out_valid, 0);

      mul_run(32'h0001_0000, 32'h0001_0000, cnt);
      chk("mul_lat", cnt, 34);
      chk("mul_otp", otp, 0);
      chk("mul_zero", zero, 1);
      chk("mul_ovf", overflow, 1);
      chk("mul_ill", illegal, 0);
      mul_run(32'd1234, 32'd5678, cnt);
      chk("mul2_lat", cnt, 34);
      chk("mul2_otp", otp, 32'd7006652);
      chk("mul2_ovf", overflow, 0);

      mul_run(32'd3, 32'd5, cnt);
      @(negedge clk);
      mul_run(32'd3, 32'd5, cnt);
      chk("mul3_otp", otp, 15);
      @(negedge clk);

      // reset in the middle of a MUL
      drive(OP_MUL, 32'd7, 32'd9);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rmid_valid", out_valid, 0);
      chk("rmid_ready", in_ready, 1);
      chk("rmid_otp", otp, 0);
      rst = 1'b0;
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("rmid_stale", cnt, 0);

      // backpressure: AND result held while OR waits at the input
      out_ready = 1'b0;
      drive(OP_AND, 32'hF0F0_1234, 32'hFF00_FF00);
      @(negedge clk);
      drive(OP_OR, 32'hF0F0_1234, 32'hFF00_FF00);
      chk("bp_otp", otp, 32'hF000_1200);
      chk("bp_ready", in_ready, 0);
      stable = 1'b1;
      repeat (10) begin
         @(negedge clk);
         stable &= otp == 32'hF000_1200 && out_valid && !overflow && !zero && !illegal && !in_ready;
      end
      chk("bp_hold", stable, 1);
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_next_valid", out_valid, 1);
      chk("bp_next_otp", otp, 32'hFFF0_FF34);

      // WIDTH=8 instance
      in_valid8 = 1'b1; alufn8 = OP_ADD; a8 = 8'h7F; b8 = 8'h01;
      @(negedge clk);
      chk("w8_add_otp", otp8, 8'h80);
      chk("w8_add_ovf", overflow8, 1);
      alufn8 = OP_MUL; a8 = 8'h10; b8 = 8'h10;
      @(negedge clk);
      in_valid8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
      cnt = 0;
      while (!out_valid8 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk("w8_mul_lat", cnt, 10);
      chk("w8_mul_otp", otp8, 0);
      chk("w8_mul_ovf", overflow8, 1);
      chk("w8_mul_zero", zero8, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
